// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus between the MEM-stage load/store unit and the memory.
// The LSU holds a request until granted and later accepts one read beat.
interface mem_stage_lsu_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// RV32I MEM-stage load/store unit: one op in flight, decodes width and
// alignment, drives the data-memory bus and returns a tagged result.
module mem_stage_lsu #(
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_is_load,
    input  logic             in_is_store,
    input  logic [2:0]       in_funct3,
    input  logic [31:0]      in_addr,
    input  logic [31:0]      in_wdata,
    input  logic [31:0]      in_alu_result,
    input  logic [TAG_W-1:0] in_tag,
    mem_stage_lsu_if.master  dmem,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_exc
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t             state_r;
    state_t             next_state_s;
    logic               out_valid_r,  next_out_valid_s;
    logic [31:0]        out_data_r,   next_out_data_s;
    logic [TAG_W-1:0]   out_tag_r,    next_out_tag_s;
    logic               out_exc_r,    next_out_exc_s;
    logic               req_r,        next_req_s;
    logic               we_r,         next_we_s;
    logic [3:0]         be_r,         next_be_s;
    logic [31:0]        addr_r,       next_addr_s;
    logic [31:0]        wdata_r,      next_wdata_s;
    logic [2:0]         ld_funct3_r,  next_ld_funct3_s;
    logic [1:0]         ld_off_r,     next_ld_off_s;

    logic               accept_s;
    logic               mem_op_s;
    logic               illegal_s;
    logic               misalign_s;
    logic [3:0]         st_be_s;
    logic [31:0]        st_wdata_s;
    logic [31:0]        shifted_s;
    logic [31:0]        load_data_s;

    assign in_ready = (state_r == ST_IDLE) || ((state_r == ST_RESP) && out_ready);
    assign accept_s = in_valid && in_ready;

    assign out_valid        = out_valid_r;
    assign out_data         = out_data_r;
    assign out_tag          = out_tag_r;
    assign out_exc          = out_exc_r;
    assign dmem.dmem_req    = req_r;
    assign dmem.dmem_we     = we_r;
    assign dmem.dmem_be     = be_r;
    assign dmem.dmem_addr   = addr_r;
    assign dmem.dmem_wdata  = wdata_r;

    // Decode the incoming op: legality, alignment and store byte lanes.
    always_comb begin
        mem_op_s   = in_is_load || in_is_store;
        illegal_s  = 1'b0;
        misalign_s = 1'b0;
        st_be_s    = 4'b1111;
        st_wdata_s = in_wdata;
        if (in_is_load && in_is_store) begin
            illegal_s = 1'b1;
        end else if (in_is_load) begin
            case (in_funct3)
                3'b011, 3'b110, 3'b111: illegal_s = 1'b1;
                default:                illegal_s = 1'b0;
            endcase
        end else if (in_is_store) begin
            illegal_s = (in_funct3 > 3'b010);
        end else begin
            illegal_s = 1'b0;
        end
        case (in_funct3[1:0])
            2'b01:   misalign_s = in_addr[0];
            2'b10:   misalign_s = |in_addr[1:0];
            default: misalign_s = 1'b0;
        endcase
        case (in_funct3)
            3'b000: begin
                st_be_s    = 4'b0001 << in_addr[1:0];
                st_wdata_s = {4{in_wdata[7:0]}};
            end
            3'b001: begin
                st_be_s    = 4'b0011 << in_addr[1:0];
                st_wdata_s = {2{in_wdata[15:0]}};
            end
            default: begin
                st_be_s    = 4'b1111;
                st_wdata_s = in_wdata;
            end
        endcase
    end

    // Align returned read data to the byte offset and apply the load extension.
    always_comb begin
        shifted_s = dmem.dmem_rdata >> {ld_off_r, 3'b000};
        case (ld_funct3_r)
            3'b000:  load_data_s = {{24{shifted_s[7]}}, shifted_s[7:0]};
            3'b100:  load_data_s = {24'h00_0000, shifted_s[7:0]};
            3'b001:  load_data_s = {{16{shifted_s[15]}}, shifted_s[15:0]};
            3'b101:  load_data_s = {16'h0000, shifted_s[15:0]};
            default: load_data_s = dmem.dmem_rdata;
        endcase
    end

    // Next-state and next-output logic; a new transfer overrides the state step.
    always_comb begin
        next_state_s     = state_r;
        next_out_valid_s = out_valid_r;
        next_out_data_s  = out_data_r;
        next_out_tag_s   = out_tag_r;
        next_out_exc_s   = out_exc_r;
        next_req_s       = req_r;
        next_we_s        = we_r;
        next_be_s        = be_r;
        next_addr_s      = addr_r;
        next_wdata_s     = wdata_r;
        next_ld_funct3_s = ld_funct3_r;
        next_ld_off_s    = ld_off_r;

        case (state_r)
            ST_IDLE: begin
                next_out_valid_s = 1'b0;
                next_req_s       = 1'b0;
            end
            ST_REQ: begin
                if (dmem.dmem_gnt) begin
                    next_req_s = 1'b0;
                    if (we_r) begin
                        next_state_s     = ST_RESP;
                        next_out_valid_s = 1'b1;
                        next_out_data_s  = 32'h0000_0000;
                        next_out_exc_s   = 1'b0;
                    end else begin
                        next_state_s = ST_WAIT;
                    end
                end else begin
                    next_req_s = 1'b1;
                end
            end
            ST_WAIT: begin
                if (dmem.dmem_rvalid) begin
                    next_state_s     = ST_RESP;
                    next_out_valid_s = 1'b1;
                    next_out_data_s  = load_data_s;
                    next_out_exc_s   = 1'b0;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (out_ready) begin
                    next_state_s     = ST_IDLE;
                    next_out_valid_s = 1'b0;
                end else begin
                    next_out_valid_s = 1'b1;
                end
            end
            default: begin
                next_state_s     = ST_IDLE;
                next_out_valid_s = 1'b0;
                next_req_s       = 1'b0;
            end
        endcase

        if (accept_s) begin
            next_out_tag_s   = in_tag;
            next_ld_funct3_s = in_funct3;
            next_ld_off_s    = in_addr[1:0];
            if (!mem_op_s) begin
                next_state_s     = ST_RESP;
                next_out_valid_s = 1'b1;
                next_out_data_s  = in_alu_result;
                next_out_exc_s   = 1'b0;
                next_req_s       = 1'b0;
            end else if (illegal_s || misalign_s) begin
                next_state_s     = ST_RESP;
                next_out_valid_s = 1'b1;
                next_out_data_s  = 32'h0000_0000;
                next_out_exc_s   = 1'b1;
                next_req_s       = 1'b0;
            end else begin
                next_state_s     = ST_REQ;
                next_out_valid_s = 1'b0;
                next_out_exc_s   = 1'b0;
                next_req_s       = 1'b1;
                next_we_s        = in_is_store;
                next_be_s        = in_is_store ? st_be_s : 4'b1111;
                next_addr_s      = {in_addr[31:2], 2'b00};
                next_wdata_s     = st_wdata_s;
            end
        end else begin
            next_ld_off_s = ld_off_r;
        end
    end

    // State and output registers with synchronous reset abandoning any op.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            out_data_r  <= 32'h0000_0000;
            out_tag_r   <= {TAG_W{1'b0}};
            out_exc_r   <= 1'b0;
            req_r       <= 1'b0;
            we_r        <= 1'b0;
            be_r        <= 4'b0000;
            addr_r      <= 32'h0000_0000;
            wdata_r     <= 32'h0000_0000;
            ld_funct3_r <= 3'b000;
            ld_off_r    <= 2'b00;
        end else begin
            state_r     <= next_state_s;
            out_valid_r <= next_out_valid_s;
            out_data_r  <= next_out_data_s;
            out_tag_r   <= next_out_tag_s;
            out_exc_r   <= next_out_exc_s;
            req_r       <= next_req_s;
            we_r        <= next_we_s;
            be_r        <= next_be_s;
            addr_r      <= next_addr_s;
            wdata_r     <= next_wdata_s;
            ld_funct3_r <= next_ld_funct3_s;
            ld_off_r    <= next_ld_off_s;
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed cases plus randomized ops
// compared against a byte-level reference model of RV32I loads and stores.
module tb_mem_stage_lsu;
    localparam int TAG_W = 6;

    typedef struct packed {
        logic        exc;
        logic        mem;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] data;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready, in_is_load, in_is_store;
    logic [2:0]       in_funct3;
    logic [31:0]      in_addr, in_wdata, in_alu_result;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid, out_ready, out_exc;
    logic [31:0]      out_data;
    logic [TAG_W-1:0] out_tag;

    int pass_cnt  = 0;
    int total_cnt = 0;

    mem_stage_lsu_if dmem_if ();

    mem_stage_lsu #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_is_load(in_is_load), .in_is_store(in_is_store),
        .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
        .in_alu_result(in_alu_result), .in_tag(in_tag),
        .dmem(dmem_if),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_exc(out_exc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", name, obs, exp);
    endtask

    // Reference model: what a single op should produce, from byte arithmetic.
    function automatic exp_t model(input bit ld, input bit st, input bit [2:0] f3,
                                   input bit [31:0] addr, input bit [31:0] wd,
                                   input bit [31:0] alu, input bit [31:0] rd);
        exp_t   e;
        int     off;
        int     size;
        bit     legal;
        longint v;
        longint m;
        e = '0;
        if (!ld && !st) begin
            e.data = alu;
            return e;
        end
        if (ld && st) begin
            e.exc = 1'b1;
            return e;
        end
        off = int'(addr % 32'd4);
        if (ld) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        else    legal = (f3 <= 3'd2);
        size = 1 << int'(f3 % 3'd4);
        if (!legal || (off % size) != 0) begin
            e.exc = 1'b1;
            return e;
        end
        e.mem  = 1'b1;
        e.we   = st;
        e.addr = addr - 32'(off);
        if (st) begin
            for (int i = 0; i < 4; i++) begin
                e.be[i] = (i >= off) && (i < off + size);
                e.wdata[8*i +: 8] = wd[8*(i % size) +: 8];
            end
        end else begin
            e.be = 4'hF;
            v = longint'(rd) >> (8 * off);
            m = longint'(1) << (8 * size);
            v = v % m;
            if (f3 < 3'd4 && size < 4 && v >= m / 2) v = v - m;
            e.data = 32'(v);
        end
        return e;
    endfunction

    // Drive one op from IDLE through to its retirement, checking every phase.
    task automatic run_op(input bit ld, input bit st, input bit [2:0] f3, input bit [31:0] addr,
                          input bit [31:0] wd, input bit [31:0] alu, input bit [31:0] rd,
                          input bit [TAG_W-1:0] tag, input int gnt_dly, input int rv_dly,
                          input int rdy_dly, input bit has_spec, input bit [31:0] spec_data,
                          input string name);
        exp_t e;
        e = model(ld, st, f3, addr, wd, alu, rd);
        in_valid = 1'b1; in_is_load = ld; in_is_store = st; in_funct3 = f3;
        in_addr = addr; in_wdata = wd; in_alu_result = alu; in_tag = tag;
        out_ready = 1'b0; dmem_if.dmem_gnt = 1'b0; dmem_if.dmem_rvalid = 1'b0;
        #1 chk({name, "_in_ready_idle"}, {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0; in_addr = $urandom; in_wdata = $urandom; in_tag = TAG_W'($urandom);
        if (e.mem) begin
            chk({name, "_req"}, {31'd0, dmem_if.dmem_req}, 32'd1);
            chk({name, "_addr"}, dmem_if.dmem_addr, e.addr);
            chk({name, "_we"}, {31'd0, dmem_if.dmem_we}, {31'd0, e.we});
            chk({name, "_be"}, {28'd0, dmem_if.dmem_be}, {28'd0, e.be});
            if (e.we) chk({name, "_wdata"}, dmem_if.dmem_wdata, e.wdata);
            chk({name, "_valid_req"}, {31'd0, out_valid}, 32'd0);
            for (int i = 0; i < gnt_dly; i++) begin
                dmem_if.dmem_rvalid = 1'($urandom_range(0, 1));
                dmem_if.dmem_rdata  = $urandom;
                tick();
                chk({name, "_req_hold"}, {31'd0, dmem_if.dmem_req}, 32'd1);
                chk({name, "_addr_hold"}, dmem_if.dmem_addr, e.addr);
                chk({name, "_be_hold"}, {28'd0, dmem_if.dmem_be}, {28'd0, e.be});
            end
            dmem_if.dmem_rvalid = 1'b0;
            dmem_if.dmem_gnt = 1'b1;
            tick();
            dmem_if.dmem_gnt = 1'b0;
            chk({name, "_req_drop"}, {31'd0, dmem_if.dmem_req}, 32'd0);
            if (!e.we) begin
                chk({name, "_valid_wait"}, {31'd0, out_valid}, 32'd0);
                for (int i = 0; i < rv_dly; i++) begin
                    dmem_if.dmem_rdata = $urandom;
                    tick();
                    chk({name, "_valid_wait"}, {31'd0, out_valid}, 32'd0);
                end
                dmem_if.dmem_rdata  = rd;
                dmem_if.dmem_rvalid = 1'b1;
                tick();
                dmem_if.dmem_rvalid = 1'b0;
                dmem_if.dmem_rdata  = $urandom;
            end
        end else begin
            chk({name, "_no_req"}, {31'd0, dmem_if.dmem_req}, 32'd0);
        end
        chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({name, "_data"}, out_data, e.data);
        chk({name, "_tag"}, {26'd0, out_tag}, {26'd0, tag});
        chk({name, "_exc"}, {31'd0, out_exc}, {31'd0, e.exc});
        if (has_spec) chk({name, "_spec_data"}, out_data, spec_data);
        for (int i = 0; i < rdy_dly; i++) begin
            dmem_if.dmem_rvalid = 1'($urandom_range(0, 1));
            dmem_if.dmem_rdata  = $urandom;
            #1 chk({name, "_in_ready_stall"}, {31'd0, in_ready}, 32'd0);
            tick();
            chk({name, "_valid_stall"}, {31'd0, out_valid}, 32'd1);
            chk({name, "_data_stall"}, out_data, e.data);
            chk({name, "_tag_stall"}, {26'd0, out_tag}, {26'd0, tag});
        end
        dmem_if.dmem_rvalid = 1'b0;
        out_ready = 1'b1;
        #1 chk({name, "_in_ready_resp"}, {31'd0, in_ready}, 32'd1);
        tick();
        out_ready = 1'b0;
        chk({name, "_retired"}, {31'd0, out_valid}, 32'd0);
        chk({name, "_req_idle"}, {31'd0, dmem_if.dmem_req}, 32'd0);
    endtask

    initial begin
        bit ld, st;
        int kind;
        rst = 1'b1; in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0;
        in_funct3 = 3'd0; in_addr = 32'd0; in_wdata = 32'd0; in_alu_result = 32'd0;
        in_tag = '0; out_ready = 1'b0;
        dmem_if.dmem_gnt = 1'b0; dmem_if.dmem_rvalid = 1'b0; dmem_if.dmem_rdata = 32'd0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_tag", {26'd0, out_tag}, 32'd0);
        chk("rst_out_exc", {31'd0, out_exc}, 32'd0);
        chk("rst_req", {31'd0, dmem_if.dmem_req}, 32'd0);
        chk("rst_we", {31'd0, dmem_if.dmem_we}, 32'd0);
        chk("rst_be", {28'd0, dmem_if.dmem_be}, 32'd0);
        chk("rst_addr", dmem_if.dmem_addr, 32'd0);
        chk("rst_wdata", dmem_if.dmem_wdata, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Directed examples.
        run_op(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'd0, 32'd0, 32'h80FF_FF00, 6'd5,
               2, 0, 0, 1'b1, 32'hFFFF_FF80, "lb");
        run_op(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'd0, 32'd0, 6'd9,
               0, 0, 1, 1'b1, 32'h0000_0000, "sh");
        run_op(1'b1, 1'b0, 3'b010, 32'h0000_3001, 32'd0, 32'd0, 32'd0, 6'd12,
               0, 0, 0, 1'b1, 32'h0000_0000, "lw_misaligned");
        run_op(1'b1, 1'b0, 3'b101, 32'h0000_4002, 32'd0, 32'd0, 32'h8001_0000, 6'd20,
               1, 1, 0, 1'b1, 32'h0000_8001, "lhu");
        run_op(1'b1, 1'b0, 3'b001, 32'h0000_4002, 32'd0, 32'd0, 32'h8001_0000, 6'd21,
               0, 2, 2, 1'b1, 32'hFFFF_8001, "lh");
        run_op(1'b0, 1'b1, 3'b000, 32'h0000_0013, 32'hDEAD_BE5A, 32'd0, 32'd0, 6'd33,
               1, 0, 0, 1'b1, 32'h0000_0000, "sb");
        run_op(1'b1, 1'b1, 3'b010, 32'h0000_0100, 32'd0, 32'd0, 32'd0, 6'd40,
               0, 0, 0, 1'b1, 32'h0000_0000, "ld_and_st");

        // Back-to-back ALU ops, then a stalled consumer.
        in_valid = 1'b1; in_is_load = 1'b0; in_is_store = 1'b0; in_funct3 = 3'd0;
        in_alu_result = 32'hAAAA_0001; in_tag = 6'd1; out_ready = 1'b1;
        tick();
        chk("b2b_first_valid", {31'd0, out_valid}, 32'd1);
        chk("b2b_first_data", out_data, 32'hAAAA_0001);
        chk("b2b_first_tag", {26'd0, out_tag}, 32'd1);
        in_alu_result = 32'h5555_0002; in_tag = 6'd2;
        #1 chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        chk("b2b_second_valid", {31'd0, out_valid}, 32'd1);
        chk("b2b_second_data", out_data, 32'h5555_0002);
        chk("b2b_second_tag", {26'd0, out_tag}, 32'd2);
        for (int i = 0; i < 3; i++) begin
            #1 chk("b2b_stall_in_ready", {31'd0, in_ready}, 32'd0);
            tick();
            chk("b2b_stall_valid", {31'd0, out_valid}, 32'd1);
            chk("b2b_stall_data", out_data, 32'h5555_0002);
            chk("b2b_stall_tag", {26'd0, out_tag}, 32'd2);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("b2b_retired", {31'd0, out_valid}, 32'd0);

        // Reset while waiting for read data; the late rvalid must be ignored.
        in_valid = 1'b1; in_is_load = 1'b1; in_is_store = 1'b0; in_funct3 = 3'b010;
        in_addr = 32'h0000_5000; in_tag = 6'd7;
        tick();
        in_valid = 1'b0;
        dmem_if.dmem_gnt = 1'b1;
        tick();
        dmem_if.dmem_gnt = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstwait_req", {31'd0, dmem_if.dmem_req}, 32'd0);
        chk("rstwait_valid", {31'd0, out_valid}, 32'd0);
        chk("rstwait_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        dmem_if.dmem_rdata = 32'h1234_5678; dmem_if.dmem_rvalid = 1'b1;
        tick();
        dmem_if.dmem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rstwait_late_valid", {31'd0, out_valid}, 32'd0);
            chk("rstwait_late_req", {31'd0, dmem_if.dmem_req}, 32'd0);
            tick();
        end

        // Randomized ops against the reference model.
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 9);
            ld = (kind == 1) || (kind >= 2 && kind <= 5);
            st = (kind == 1) || (kind >= 6);
            run_op(ld, st, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, $urandom,
                   TAG_W'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 2), 1'b0, 32'd0, "rand");
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/mem_stage_lsu.md
MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 SHALL have parameter TAG_W, default 6, width of destination ROB tag.
REQ-002 SHALL use one clock; reset is synchronous and active-high. Ports: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-003 SHALL have in_valid  in  1  EX/MEM register holds valid op; in_ready  out  1  stage accepts op this cycle.
REQ-004 SHALL have in_is_load  in  1; in_is_store  in  1; in_funct3  in  3  RV32I width code; in_addr  in  32  effective address; in_wdata  in  32  store data (rs2); in_alu_result  in  32  result for non-memory ops; in_tag  in  TAG_W  destination tag.
REQ-005 SHALL have dmem_req  out  1; dmem_we  out  1; dmem_addr  out  32  word-aligned; dmem_be  out  4  byte enables; dmem_wdata  out  32; dmem_gnt  in  1  request accepted; dmem_rvalid  in  1  read data valid; dmem_rdata  in  32.
REQ-006 SHALL have out_valid  out  1; out_ready  in  1; out_data  out  32; out_tag  out  TAG_W; out_exc  out  1  misaligned/illegal access.

Function
REQ-007 SHALL implement FSM states IDLE, REQ, WAIT, RESP; all outputs registered except in_ready.
REQ-008 in_ready SHALL be 1 in IDLE, or in RESP when out_ready=1; 0 otherwise. Transfer in = in_valid & in_ready.
REQ-009 On transfer, op with in_is_load=0 and in_is_store=0: out_data<=in_alu_result, out_exc<=0, go RESP (1-cycle latency).
REQ-010 On transfer, memory op illegal SHALL go RESP with out_exc=1, out_data=0, no dmem request. Illegal = both is_load and is_store; load funct3 in {011,110,111}; store funct3 > 010; halfword with addr[0]=1; word with addr[1:0]!=0.
REQ-011 On transfer, legal memory op SHALL go REQ; dmem_addr={addr[31:2],2'b00}; dmem_we=is_store.
REQ-012 Store lanes: SB be=0001<<addr[1:0], wdata={4{wdata[7:0]}}; SH be=0011<<addr[1:0], wdata={2{wdata[15:0]}}; SW be=1111, wdata=wdata. Loads: be=1111.
REQ-013 In REQ, dmem_req=1 and dmem_addr/we/be/wdata SHALL stay stable until cycle with dmem_gnt=1; store then goes RESP (out_data=0), load goes WAIT. dmem_req=0 in all other states.
REQ-014 dmem_rvalid SHALL be ignored outside WAIT (memory returns rvalid at least 1 cycle after gnt).
REQ-015 In WAIT, on dmem_rvalid: x = dmem_rdata >> (8*addr[1:0]); LB sign-extend x[7:0]; LBU zero-extend x[7:0]; LH sign-extend x[15:0]; LHU zero-extend x[15:0]; LW rdata; go RESP.
REQ-016 In RESP, out_valid=1 and out_data/out_tag/out_exc SHALL hold until out_ready=1; then go IDLE, or, if new transfer same cycle, process it per REQ-009..011 (back-to-back, no bubble).
REQ-017 out_tag SHALL equal in_tag captured at transfer.
REQ-018 No unbounded wait timeout; stage holds indefinitely on missing gnt/rvalid/out_ready.

Reset
REQ-019 rst=1 at clock edge SHALL force IDLE, out_valid=0, out_exc=0, out_data=0, out_tag=0, dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0.
REQ-020 Reset mid-operation (REQ/WAIT/RESP) SHALL abandon op; dmem_req low from cycle after reset edge; late rvalid after reset ignored.

Verification
REQ-021 LB addr=0x1003, rdata=0x80FF_FF00, gnt after 2 cycles, rvalid 1 later -> out_data=0xFFFF_FF80, out_exc=0, dmem_addr=0x1000.
REQ-022 SH addr=0x2002, wdata=0x1234_ABCD -> dmem_be=1100, dmem_wdata=0xABCD_ABCD, dmem_we=1, out_valid 1 cycle after gnt, out_data=0.
REQ-023 LW addr=0x3001 -> no dmem_req, out_valid next cycle, out_exc=1, out_data=0.
REQ-024 Two ALU ops back-to-back, out_ready=1 -> out_valid continuous 2 cycles, results in order, tags match; with out_ready=0 for 3 cycles -> outputs stable, in_ready=0.
REQ-025 LHU addr=0x4002, rdata=0x8001_0000 -> out_data=0x0000_8001; LH same -> 0xFFFF_8001.
REQ-026 rst asserted in WAIT, rvalid 2 cycles later -> IDLE, out_valid stays 0, dmem_req=0.
